// File: rtl/types_pkg.sv
// Shared types for the load/store memory access controller.
// mem_width encodings are the RV32I load/store funct3 codes.
package types_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_width;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mem_ctrl_state;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and lane select / extension for loads.
// Also reports whether funct3 is a legal width for the requested direction.
module mem_lane_align
  import types_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_legal,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];

  // Unsigned widths exist only for loads, so they are illegal on stores.
  always_comb begin
    o_legal = 1'b0;
    o_we    = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_funct3)
      LB: begin
        o_legal = 1'b1;
        o_we    = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      LH: begin
        o_legal = 1'b1;
        o_we    = 4'b0011 << {i_addr[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      LW: begin
        o_legal = 1'b1;
        o_we    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      LBU: begin
        o_legal = ~i_write;
        o_rdata = {24'h0, w_byte};
      end
      LHU: begin
        o_legal = ~i_write;
        o_rdata = {16'h0, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the datapath and a 1-cycle sync-read data RAM.
// Optional macro MISALIGN_TRAP_EN: trap misaligned lh/lhu/sh/lw/sw instead of forcing alignment.
module mem_access_ctrl
  import types_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  mem_ctrl_state     r_state;
  mem_ctrl_state     w_next_state;
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [MEM_AW+1:0] r_addr;
  logic [31:0]       r_wdata;

  logic        w_ready;
  logic        w_accept;
  logic        w_legal;
  logic        w_trap;
  logic        w_rsp_valid;
  logic        w_mem_en;
  logic [3:0]  w_mem_we;
  logic [3:0]  w_lane_we;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = &{1'b0, req_addr[31:MEM_AW+2]};

  mem_lane_align u_lane_align (
    .i_write  (r_write),
    .i_funct3 (r_funct3),
    .i_addr   (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_rdata),
    .o_legal  (w_legal),
    .o_we     (w_lane_we),
    .o_wdata  (w_lane_wdata),
    .o_rdata  (w_lane_rdata)
  );

`ifdef MISALIGN_TRAP_EN
  assign w_trap = w_legal &
                  ((((r_funct3 == LH) | (r_funct3 == LHU)) & r_addr[0]) |
                   ((r_funct3 == LW) & (r_addr[1:0] != 2'b00)));
  assign misalign = (r_state == ISSUE) & w_trap & ~rst;
`else
  assign w_trap = 1'b0;
`endif

  assign w_ready  = (r_state == IDLE);
  assign w_accept = w_ready & req_valid & ~rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Capture the request once so later req_* activity cannot disturb the access in flight.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write  <= req_write;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr[MEM_AW+1:0];
      r_wdata  <= req_wdata;
    end
  end

  // Illegal or trapped requests complete in ISSUE without touching memory.
  always_comb begin
    w_next_state = r_state;
    w_mem_en     = 1'b0;
    w_mem_we     = 4'b0000;
    w_rsp_valid  = 1'b0;
    w_rdata      = 32'h0;
    case (r_state)
      IDLE: begin
        if (req_valid) w_next_state = ISSUE;
      end
      ISSUE: begin
        if (!w_legal || w_trap) begin
          w_rsp_valid  = 1'b1;
          w_next_state = IDLE;
        end else if (r_write) begin
          w_mem_en     = 1'b1;
          w_mem_we     = w_lane_we;
          w_rsp_valid  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_mem_en     = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        w_rsp_valid  = 1'b1;
        w_rdata      = w_lane_rdata;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign req_ready = w_ready & ~rst;
  assign rsp_valid = w_rsp_valid & ~rst;
  assign rsp_rdata = w_rdata & {32{~rst}};
  assign stall     = req_valid & ~rsp_valid;
  assign mem_en    = w_mem_en & ~rst;
  assign mem_we    = w_mem_we & {4{~rst}};
  assign mem_addr  = r_addr[MEM_AW+1:2];
  assign mem_wdata = w_lane_wdata;

endmodule
